// File: rtl/popcnt_accum_pkg.sv
// Shared types and width rules for the popcount frame accumulator.
package popcnt_accum_pkg;

    localparam int unsigned WEIGHT_W = 6;

    typedef enum logic [0:0] {
        StAccum = 1'b0,
        StHold  = 1'b1
    } state_t;

    function automatic int unsigned sum_width(input int unsigned cnt_w);
        return cnt_w + WEIGHT_W;
    endfunction

endpackage

// File: rtl/popcnt_accum_hamm.sv
// Combinational 32-bit population count with an 8-bit result.
module popcnt_accum_hamm (
    input  logic [31:0] i_data,
    output logic [7:0]  o_cnt
);

    logic [7:0] w_cnt;

    always_comb begin
        w_cnt = 8'd0;
        for (int i = 0; i < 32; i++) begin
            w_cnt = w_cnt + {7'd0, i_data[i]};
        end
    end

    assign o_cnt = w_cnt;

endmodule

// File: rtl/popcnt_accum.sv
// Per-frame popcount accumulator: sum, word count, max weight and its first index.
module popcnt_accum
    import popcnt_accum_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CNT_W+WEIGHT_W-1:0]   out_sum,
    output logic [CNT_W-1:0]            out_count,
    output logic [WEIGHT_W-1:0]         out_max_w,
    output logic [CNT_W-1:0]            out_max_idx,
    output logic                        out_ovf
);

    localparam int unsigned SUM_W = sum_width(CNT_W);

    state_t              r_state;
    state_t              w_state_d;
    logic [SUM_W-1:0]    r_sum;
    logic [CNT_W-1:0]    r_count;
    logic [WEIGHT_W-1:0] r_max;
    logic [CNT_W-1:0]    r_idx;
    logic                r_ovf;

    logic [7:0]          w_hamm;
    logic [WEIGHT_W-1:0] w_weight;
    logic                w_unused_hamm;
    logic                w_acc;
    logic                w_first;
    logic                w_cnt_full;
    logic                w_drain;

    popcnt_accum_hamm HAMM_32bit (
        .i_data (in_data),
        .o_cnt  (w_hamm)
    );

    // Weight never exceeds 32, so the top two bits are always zero.
    assign w_weight      = w_hamm[WEIGHT_W-1:0];
    assign w_unused_hamm = ^w_hamm[7:WEIGHT_W];

    assign in_ready   = (r_state == StAccum);
    assign out_valid  = (r_state == StHold);
    assign w_acc      = in_valid && in_ready;
    assign w_drain    = out_valid && out_ready;
    // Count only returns to zero on a clear, so zero marks the first word.
    assign w_first    = (r_count == '0);
    assign w_cnt_full = &r_count;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StAccum: if (w_acc && in_last) w_state_d = StHold;
            StHold:  if (out_ready)        w_state_d = StAccum;
            default: w_state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StAccum;
            r_sum   <= '0;
            r_count <= '0;
            r_max   <= '0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_drain) begin
                r_sum   <= '0;
                r_count <= '0;
                r_max   <= '0;
                r_idx   <= '0;
                r_ovf   <= 1'b0;
            end else if (w_acc) begin
                r_sum <= r_sum + SUM_W'(w_weight);
                if (w_cnt_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
                if (w_first || (w_weight > r_max)) begin
                    r_max <= w_weight;
                    r_idx <= r_count;
                end
            end
        end
    end

    assign out_sum     = r_sum;
    assign out_count   = r_count;
    assign out_max_w   = r_max;
    assign out_max_idx = r_idx;
    assign out_ovf     = r_ovf;

endmodule

// File: tb/tb_popcnt_accum.sv
// Directed and randomised-gap checks of popcnt_accum against hand values and a small model.
module tb_popcnt_accum;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [31:0] in_data;
    logic [21:0] out_sum;
    logic [15:0] out_count, out_max_idx;
    logic [5:0]  out_max_w;

    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
    logic [31:0] b_in_data;
    logic [7:0]  b_out_sum;
    logic [1:0]  b_out_count, b_out_max_idx;
    logic [5:0]  b_out_max_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    popcnt_accum #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_count   (out_count),
        .out_max_w   (out_max_w),
        .out_max_idx (out_max_idx),
        .out_ovf     (out_ovf)
    );

    popcnt_accum #(.CNT_W(2)) dut_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .in_data     (b_in_data),
        .in_last     (b_in_last),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_sum     (b_out_sum),
        .out_count   (b_out_count),
        .out_max_w   (b_out_max_w),
        .out_max_idx (b_out_max_idx),
        .out_ovf     (b_out_ovf)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one word; in_ready sampled before each edge tells whether that edge accepts it.
    task automatic push(input logic [31:0] d, input logic last);
        logic rdy;
        int   n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        do begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) check_eq("push in_ready timeout", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_data  = $urandom;
    endtask

    task automatic collect(input int hold, input logic [63:0] esum, input logic [63:0] ecnt,
                           input logic [63:0] emax, input logic [63:0] eidx,
                           input logic eovf, input string tag);
        @(negedge clk);
        check_eq({tag, " out_valid"}, {63'd0, out_valid}, 64'd1);
        repeat (hold) @(negedge clk);
        check_eq({tag, " sum"},     {42'd0, out_sum},     esum);
        check_eq({tag, " count"},   {48'd0, out_count},   ecnt);
        check_eq({tag, " max_w"},   {58'd0, out_max_w},   emax);
        check_eq({tag, " max_idx"}, {48'd0, out_max_idx}, eidx);
        check_eq({tag, " ovf"},     {63'd0, out_ovf},     {63'd0, eovf});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          nw, w, m_sum, m_cnt, m_max, m_idx;

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        check_eq("rst in_ready",  {63'd0, in_ready},    64'd1);
        check_eq("rst out_valid", {63'd0, out_valid},   64'd0);
        check_eq("rst sum",       {42'd0, out_sum},     64'd0);
        check_eq("rst count",     {48'd0, out_count},   64'd0);
        check_eq("rst max_w",     {58'd0, out_max_w},   64'd0);
        check_eq("rst max_idx",   {48'd0, out_max_idx}, 64'd0);
        check_eq("rst ovf",       {63'd0, out_ovf},     64'd0);
        check_eq("rst small rdy", {63'd0, b_in_ready},  64'd1);

        // Saturation on the 2-bit counter instance: five back-to-back words of weight 1.
        @(posedge clk);
        #1;
        b_in_valid = 1'b1;
        b_in_data  = 32'h1;
        for (int i = 0; i < 5; i++) begin
            b_in_last = (i == 4);
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        @(negedge clk);
        check_eq("sat out_valid", {63'd0, b_out_valid},   64'd1);
        check_eq("sat count",     {62'd0, b_out_count},   64'd3);
        check_eq("sat ovf",       {63'd0, b_out_ovf},     64'd1);
        check_eq("sat sum",       {56'd0, b_out_sum},     64'd5);
        check_eq("sat max_idx",   {62'd0, b_out_max_idx}, 64'd0);
        check_eq("sat max_w",     {58'd0, b_out_max_w},   64'd1);
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;

        push(32'hFFFF_FFFF, 1'b0);
        push(32'h0000_000F, 1'b0);
        push(32'h0000_0000, 1'b1);
        collect(0, 36, 3, 32, 0, 1'b0, "f3");

        push(32'h0000_000F, 1'b0);
        push(32'h0000_00F0, 1'b1);
        collect(0, 8, 2, 4, 0, 1'b0, "tie");

        push(32'h0000_0001, 1'b0);
        push(32'h0000_0007, 1'b0);
        push(32'h0000_0003, 1'b1);
        collect(1, 6, 3, 3, 1, 1'b0, "mid");

        push(32'h8000_0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold out_valid", {63'd0, out_valid}, 64'd1);
            check_eq("hold sum",       {42'd0, out_sum},   64'd2);
            check_eq("hold count",     {48'd0, out_count}, 64'd1);
            check_eq("hold in_ready",  {63'd0, in_ready},  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("rel in_ready",  {63'd0, in_ready},  64'd1);
        check_eq("rel out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rel sum clr",   {42'd0, out_sum},   64'd0);

        // Reset in the middle of a frame discards the partial result.
        push(32'h0000_FFFF, 1'b0);
        push(32'h00FF_0000, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mrst in_ready",  {63'd0, in_ready},  64'd1);
        check_eq("mrst out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("mrst count",     {48'd0, out_count}, 64'd0);
        push(32'h0000_0003, 1'b1);
        collect(0, 2, 1, 2, 0, 1'b0, "postrst");

        for (int f = 0; f < 1000; f++) begin
            nw = $urandom_range(1, 6);
            m_sum = 0; m_cnt = 0; m_max = 0; m_idx = 0;
            for (int k = 0; k < nw; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    in_data = $urandom;
                    in_last = 1'b1;
                    @(posedge clk);
                    #1;
                end
                case ($urandom_range(0, 3))
                    0:       d = $urandom;
                    1:       d = $urandom & $urandom & $urandom;
                    2:       d = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
                    default: d = 32'h1 << $urandom_range(0, 31);
                endcase
                w = $countones(d);
                if (m_cnt == 0 || w > m_max) begin
                    m_max = w;
                    m_idx = m_cnt;
                end
                m_sum += w;
                m_cnt++;
                push(d, k == nw - 1);
            end
            collect($urandom_range(0, 3), m_sum, m_cnt, m_max, m_idx, 1'b0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
